if_id_pipe_reg: RTL and testbench

- Parametrised fetch-to-decode pipeline register, the successor of the plain IF/ID latch.
- Carries instruction, PC and PC+4 from fetch to decode.
- Adds per-stage valid tracking, stall (hold), flush (bubble insertion with a canonical NOP), and saturating stall/flush event counters for performance debug.
- Sits between the fetch stage and the decoder/register-file read stage; StallD and FlushD are driven by the hazard unit.

---
 rtl/if_id_if.sv | 29 ++
 rtl/if_id_pipe_reg.sv | 74 +++++++
 tb/tb_if_id_pipe_reg.sv | 136 +++++++++++++
 3 files changed

// File: rtl/if_id_if.sv
// Fetch-to-decode bus: the F-side payload, the hazard-unit controls, the
// registered D-side outputs and the performance counters.
interface if_id_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] InstrF;
  logic [ADDR_W-1:0] PCF;
  logic [ADDR_W-1:0] PCPlus4F;
  logic              ValidF;
  logic              StallD;
  logic              FlushD;
  logic [DATA_W-1:0] InstrD;
  logic [ADDR_W-1:0] PCD;
  logic [ADDR_W-1:0] PCPlus4D;
  logic              ValidD;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  FlushCount;

  modport master (
    output InstrF, PCF, PCPlus4F, ValidF, StallD, FlushD,
    input  InstrD, PCD, PCPlus4D, ValidD, StallCount, FlushCount
  );
  modport slave (
    input  InstrF, PCF, PCPlus4F, ValidF, StallD, FlushD,
    output InstrD, PCD, PCPlus4D, ValidD, StallCount, FlushCount
  );
endinterface

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid tracking, stall/flush handling and
// saturating stall/flush event counters. Priority: reset > flush > stall > load.
module if_id_pipe_reg #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013,
  parameter int                CNT_W     = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  if_id_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] instr_q,     instr_d;
  logic [ADDR_W-1:0] pc_q,        pc_d;
  logic [ADDR_W-1:0] pc_plus4_q,  pc_plus4_d;
  logic              valid_q,     valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              stall_hit, flush_hit;

  always_comb begin
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;

    // A flush under stall discards the held D instruction, otherwise the incoming F one.
    flush_hit = bus.FlushD & (bus.StallD ? valid_q : bus.ValidF);
    stall_hit = bus.StallD & ~bus.FlushD & valid_q;

    if (bus.FlushD) begin
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      pc_d       = bus.PCF;
      pc_plus4_d = bus.PCPlus4F;
    end else if (!bus.StallD) begin
      // Mux on ValidF so undefined F data never reaches InstrD.
      instr_d    = bus.ValidF ? bus.InstrF : NOP_INSTR;
      valid_d    = bus.ValidF;
      pc_d       = bus.PCF;
      pc_plus4_d = bus.PCPlus4F;
    end

    stall_cnt_d = (stall_hit && stall_cnt_q != '1) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
    flush_cnt_d = (flush_hit && flush_cnt_q != '1) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q     <= NOP_INSTR;
      pc_q        <= '0;
      pc_plus4_q  <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      pc_plus4_q  <= pc_plus4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.InstrD     = instr_q;
  assign bus.PCD        = pc_q;
  assign bus.PCPlus4D   = pc_plus4_q;
  assign bus.ValidD     = valid_q;
  assign bus.StallCount = stall_cnt_q;
  assign bus.FlushCount = flush_cnt_q;
endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Directed bench for if_id_pipe_reg: a 16-bit-counter instance for the main
// scenarios and a 4-bit-counter instance for saturation.
module tb_if_id_pipe_reg;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n, rst2_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  if_id_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(16)) b1 ();
  if_id_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(4))  b2 ();

  if_id_pipe_reg #(.DATA_W(32), .ADDR_W(32), .NOP_INSTR(NOP), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  if_id_pipe_reg #(.DATA_W(32), .ADDR_W(32), .NOP_INSTR(NOP), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst2_n), .bus(b2.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    b1.ValidF = 1'b1; b1.InstrF = 32'hDEADBEEF; b1.PCF = 32'h50; b1.PCPlus4F = 32'h54;
    b1.StallD = 1'b0; b1.FlushD = 1'b0;
    tick(); tick();
    checks++; if (b1.InstrD !== NOP) begin errors++; $display("FAIL reset_instr got=%h exp=%h", b1.InstrD, NOP); end
    checks++; if (b1.PCD !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", b1.PCD); end
    checks++; if (b1.PCPlus4D !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h exp=0", b1.PCPlus4D); end
    checks++; if (b1.ValidD !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", b1.ValidD); end
    checks++; if (b1.StallCount !== 16'h0) begin errors++; $display("FAIL reset_stallcnt got=%h exp=0", b1.StallCount); end
    checks++; if (b1.FlushCount !== 16'h0) begin errors++; $display("FAIL reset_flushcnt got=%h exp=0", b1.FlushCount); end
  endtask

  task automatic test_load();
    rst_n = 1'b1;
    b1.InstrF = 32'h00500093; b1.PCF = 32'h100; b1.PCPlus4F = 32'h104; b1.ValidF = 1'b1;
    tick();
    checks++; if (b1.InstrD !== 32'h00500093) begin errors++; $display("FAIL load_instr got=%h exp=00500093", b1.InstrD); end
    checks++; if (b1.PCD !== 32'h100) begin errors++; $display("FAIL load_pc got=%h exp=100", b1.PCD); end
    checks++; if (b1.PCPlus4D !== 32'h104) begin errors++; $display("FAIL load_pc4 got=%h exp=104", b1.PCPlus4D); end
    checks++; if (b1.ValidD !== 1'b1) begin errors++; $display("FAIL load_valid got=%b exp=1", b1.ValidD); end
  endtask

  task automatic test_stall();
    b1.StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b1.InstrF = 32'hA000_0000 + i; b1.PCF = 32'h300 + 4*i; b1.PCPlus4F = 32'h304 + 4*i;
      b1.ValidF = i[0];
      tick();
      checks++; if (b1.InstrD !== 32'h00500093 || b1.PCD !== 32'h100 || b1.PCPlus4D !== 32'h104 || b1.ValidD !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d] got instr=%h pc=%h pc4=%h v=%b exp 00500093/100/104/1", i, b1.InstrD, b1.PCD, b1.PCPlus4D, b1.ValidD);
      end
      checks++; if (b1.StallCount !== 16'(i + 1)) begin errors++; $display("FAIL stall_cnt[%0d] got=%0d exp=%0d", i, b1.StallCount, i + 1); end
    end
    b1.StallD = 1'b0;
    b1.InstrF = 32'h00A00113; b1.PCF = 32'h104; b1.PCPlus4F = 32'h108; b1.ValidF = 1'b1;
    tick();
    checks++; if (b1.InstrD !== 32'h00A00113 || b1.PCD !== 32'h104 || b1.ValidD !== 1'b1) begin
      errors++; $display("FAIL stall_release got instr=%h pc=%h v=%b exp 00a00113/104/1", b1.InstrD, b1.PCD, b1.ValidD);
    end
    checks++; if (b1.StallCount !== 16'd3) begin errors++; $display("FAIL stall_cnt_after got=%0d exp=3", b1.StallCount); end
  endtask

  task automatic test_flush_over_stall();
    // ValidF=0 here: the counted victim must be the held, valid D instruction.
    b1.StallD = 1'b1; b1.FlushD = 1'b1;
    b1.ValidF = 1'b0; b1.InstrF = 32'h11111111; b1.PCF = 32'h108; b1.PCPlus4F = 32'h10C;
    tick();
    checks++; if (b1.InstrD !== NOP) begin errors++; $display("FAIL flush_instr got=%h exp=%h", b1.InstrD, NOP); end
    checks++; if (b1.ValidD !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", b1.ValidD); end
    checks++; if (b1.PCD !== 32'h108 || b1.PCPlus4D !== 32'h10C) begin errors++; $display("FAIL flush_pc got=%h/%h exp=108/10c", b1.PCD, b1.PCPlus4D); end
    checks++; if (b1.FlushCount !== 16'd1) begin errors++; $display("FAIL flush_cnt got=%0d exp=1", b1.FlushCount); end
    checks++; if (b1.StallCount !== 16'd3) begin errors++; $display("FAIL flush_stallcnt got=%0d exp=3", b1.StallCount); end
    b1.StallD = 1'b0; b1.FlushD = 1'b0;
  endtask

  task automatic test_invalid_fetch();
    b1.ValidF = 1'b0; b1.InstrF = 32'hFFFFFFFF; b1.PCF = 32'h200; b1.PCPlus4F = 32'h204;
    tick();
    checks++; if (b1.InstrD !== NOP || b1.ValidD !== 1'b0) begin errors++; $display("FAIL inv_instr got=%h v=%b exp=%h v=0", b1.InstrD, b1.ValidD, NOP); end
    checks++; if (b1.PCD !== 32'h200 || b1.PCPlus4D !== 32'h204) begin errors++; $display("FAIL inv_pc got=%h/%h exp=200/204", b1.PCD, b1.PCPlus4D); end
    b1.FlushD = 1'b1; b1.PCF = 32'h204; b1.PCPlus4F = 32'h208;
    tick();
    checks++; if (b1.FlushCount !== 16'd1) begin errors++; $display("FAIL inv_flush_cnt got=%0d exp=1", b1.FlushCount); end
    // Flush without stall discards the valid F instruction.
    b1.ValidF = 1'b1; b1.InstrF = 32'h22222222;
    tick();
    checks++; if (b1.FlushCount !== 16'd2 || b1.InstrD !== NOP) begin errors++; $display("FAIL flushF_cnt got=%0d instr=%h exp=2/%h", b1.FlushCount, b1.InstrD, NOP); end
    // Stall with an empty D slot is not counted.
    b1.FlushD = 1'b0; b1.StallD = 1'b1;
    tick();
    checks++; if (b1.StallCount !== 16'd3 || b1.ValidD !== 1'b0) begin errors++; $display("FAIL stall_empty got cnt=%0d v=%b exp=3/0", b1.StallCount, b1.ValidD); end
    // Undefined F data with ValidF=0 must load as the NOP.
    b1.StallD = 1'b0; b1.ValidF = 1'b0; b1.InstrF = 'x; b1.PCF = 32'h300; b1.PCPlus4F = 32'h304;
    tick();
    checks++; if (b1.InstrD !== NOP) begin errors++; $display("FAIL x_block got=%h exp=%h", b1.InstrD, NOP); end
  endtask

  task automatic test_saturation();
    rst2_n = 1'b1;
    b2.StallD = 1'b0; b2.FlushD = 1'b0;
    b2.ValidF = 1'b1; b2.InstrF = 32'h00300193; b2.PCF = 32'h400; b2.PCPlus4F = 32'h404;
    tick();
    b2.StallD = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15 || i == 20) begin
        checks++; if (b2.StallCount !== 4'hF) begin errors++; $display("FAIL sat_cnt[%0d] got=%h exp=f", i, b2.StallCount); end
      end
    end
    checks++; if (b2.ValidD !== 1'b1 || b2.InstrD !== 32'h00300193) begin errors++; $display("FAIL sat_hold got instr=%h v=%b exp=00300193/1", b2.InstrD, b2.ValidD); end
    rst2_n = 1'b0;
    tick();
    checks++; if (b2.StallCount !== 4'h0 || b2.ValidD !== 1'b0 || b2.InstrD !== NOP) begin
      errors++; $display("FAIL sat_reset got cnt=%h v=%b instr=%h exp=0/0/%h", b2.StallCount, b2.ValidD, b2.InstrD, NOP);
    end
  endtask

  initial begin
    b2.ValidF = 1'b0; b2.InstrF = '0; b2.PCF = '0; b2.PCPlus4F = '0;
    b2.StallD = 1'b0; b2.FlushD = 1'b0;
    test_reset();
    test_load();
    test_stall();
    test_flush_over_stall();
    test_invalid_fetch();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
